// File: rtl/switch_event_scanner.sv
// switch_event_scanner
//   Samples WIDTH raw switch/button lines, synchronizes and debounces them
//   against a shared sample tick, and reports every accepted level change as
//   an {index, direction} event through a small valid/ready FIFO.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous active-high reset
//   s_i          raw asynchronous switch inputs
//   level_o      debounced levels
//   evt_valid_o  FIFO head event available
//   evt_ready_i  consumer accepts head event
//   evt_idx_o    line index of head event
//   evt_rise_o   1 = head event is a rising change, 0 = falling
//   overflow_o   sticky: a change was merged into an already pending event
//   clr_ovf_i    single-cycle clear of overflow_o (a simultaneous set wins)
module switch_event_scanner #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned TICK_DIV     = 1200,
  parameter int unsigned STABLE_TICKS = 50,
  parameter int unsigned FIFO_DEPTH   = 4,
  localparam int unsigned IW   = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1,
  localparam int unsigned CW   = $clog2(STABLE_TICKS + 1),
  localparam int unsigned PTRW = $clog2(FIFO_DEPTH),
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] s_i,
  output logic [WIDTH-1:0] level_o,
  output logic             evt_valid_o,
  input  logic             evt_ready_i,
  output logic [IW-1:0]    evt_idx_o,
  output logic             evt_rise_o,
  output logic             overflow_o,
  input  logic             clr_ovf_i
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic             tick;

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] toggled;

  logic [WIDTH-1:0] pend_q, pend_d, push_clr, pend_kept;
  logic             ovf_q, ovf_d;

  logic [IW-1:0]    push_idx;
  logic             found, push, pop, can_push;

  logic [IW:0]      mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]  wr_q, rd_q;
  logic [CNTW-1:0]  fcnt_q;

  // Prescaler: one-cycle tick every TICK_DIV clocks
  assign tick    = (presc_q == PW'(TICK_DIV - 1));
  assign presc_d = tick ? '0 : presc_q + 1'b1;

  // Per-line debounce: a change is accepted on the tick where the counter
  // would reach STABLE_TICKS; any matching sample restarts qualification.
  always_comb begin
    level_d = level_q;
    toggled = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != level_q[i]) begin
          if (cnt_q[i] == CW'(STABLE_TICKS - 1)) begin
            cnt_d[i]   = '0;
            level_d[i] = ~level_q[i];
            toggled[i] = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  // Lowest-index pending line wins
  always_comb begin
    push_idx = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (pend_q[i] && !found) begin
        found    = 1'b1;
        push_idx = IW'(i);
      end
    end
  end

  assign pop      = (fcnt_q != '0) && evt_ready_i;
  assign can_push = (fcnt_q < CNTW'(FIFO_DEPTH)) || pop;
  assign push     = found && can_push;

  // A line whose event leaves this cycle may queue a fresh one; only a
  // toggle onto a pending bit that is not being pushed is a merge.
  always_comb begin
    push_clr = '0;
    if (push) push_clr[push_idx] = 1'b1;
    pend_kept = pend_q & ~push_clr;
    pend_d    = pend_kept | toggled;
    ovf_d     = ovf_q;
    if (clr_ovf_i) ovf_d = 1'b0;
    if (|(toggled & pend_kept)) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
      level_q <= '0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= s_i;
      sync2_q <= sync1_q;
      presc_q <= presc_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Event FIFO; entry = {idx, rise} sampled from the current level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= {push_idx, level_q[push_idx]};
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      if (push && !pop)      fcnt_q <= fcnt_q + 1'b1;
      else if (pop && !push) fcnt_q <= fcnt_q - 1'b1;
    end
  end

  assign level_o     = level_q;
  assign overflow_o  = ovf_q;
  assign evt_valid_o = (fcnt_q != '0);
  assign evt_idx_o   = mem_q[rd_q][IW:1];
  assign evt_rise_o  = mem_q[rd_q][0];

endmodule

// File: tb/tb_switch_event_scanner.sv
module tb_switch_event_scanner;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] s;
  logic [7:0] level;
  logic       valid;
  logic       ready;
  logic [2:0] idx;
  logic       rise;
  logic       ovf;
  logic       clr;

  always #5 clk = ~clk;

  switch_event_scanner #(
    .WIDTH(8),
    .TICK_DIV(4),
    .STABLE_TICKS(3),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .s_i(s),
    .level_o(level),
    .evt_valid_o(valid),
    .evt_ready_i(ready),
    .evt_idx_o(idx),
    .evt_rise_o(rise),
    .overflow_o(ovf),
    .clr_ovf_i(clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply a new input pattern and give it ample time to qualify
  task automatic settle(input logic [7:0] v);
    @(negedge clk);
    s = v;
    repeat (40) @(negedge clk);
  endtask

  // Expected events: every changed line, ascending index, direction = new level
  task automatic drain(input logic [7:0] diff, input logic [7:0] nl, input string tag);
    @(negedge clk);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (diff[i]) begin
        int b = 0;
        while (!valid && b < 20) begin
          @(negedge clk);
          b++;
        end
        check($sformatf("%s valid%0d", tag, i), valid, 1);
        check($sformatf("%s idx%0d", tag, i), idx, i);
        check($sformatf("%s rise%0d", tag, i), rise, nl[i]);
        @(negedge clk);
      end
    end
    ready = 1'b0;
    repeat (3) @(negedge clk);
    check($sformatf("%s empty", tag), valid, 0);
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] lvl;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [7:0] prev, diff;
    int lat, lo;

    vecs[0] = '{s: 8'h00, lvl: 8'h00};
    vecs[1] = '{s: 8'h81, lvl: 8'h81};
    vecs[2] = '{s: 8'h00, lvl: 8'h00};
    vecs[3] = '{s: 8'h7E, lvl: 8'h7E};
    vecs[4] = '{s: 8'h81, lvl: 8'h81};
    vecs[5] = '{s: 8'hFF, lvl: 8'hFF};
    vecs[6] = '{s: 8'h00, lvl: 8'h00};

    rst = 1'b1; s = 8'h00; ready = 1'b0; clr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset level", level, 8'h00);
    check("reset valid", valid, 0);
    check("reset idx", idx, 0);
    check("reset rise", rise, 0);
    check("reset ovf", ovf, 0);
    rst = 1'b0;

    // Clean rise on line 2 with latency window
    @(negedge clk);
    s = 8'h04;
    lat = 0;
    while (level !== 8'h04 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("rise level", level, 8'h04);
    check("rise latency window", (lat >= 11 && lat <= 14), 1);
    check("rise valid not yet", valid, 0);
    @(negedge clk);
    check("rise valid", valid, 1);
    check("rise idx", idx, 2);
    check("rise dir", rise, 1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("rise popped", valid, 0);

    // Bounce on line 0: 2 ticks high, 1 low, 2 high, then low
    @(negedge clk); s = 8'h05;
    repeat (8) @(negedge clk); s = 8'h04;
    repeat (4) @(negedge clk); s = 8'h05;
    repeat (8) @(negedge clk); s = 8'h04;
    repeat (40) @(negedge clk);
    check("bounce level", level, 8'h04);
    check("bounce valid", valid, 0);
    check("bounce ovf", ovf, 0);

    // Table: ready held low while settling, then drain and compare
    prev = 8'h04;
    for (int v = 0; v < 7; v++) begin
      settle(vecs[v].s);
      diff = prev ^ vecs[v].lvl;
      check($sformatf("vec%0d level", v), level, vecs[v].lvl);
      check($sformatf("vec%0d ovf", v), ovf, 0);
      lo = 0;
      for (int i = 7; i >= 0; i--) if (diff[i]) lo = i;
      check($sformatf("vec%0d head valid", v), valid, 1);
      check($sformatf("vec%0d head idx", v), idx, lo);
      repeat (5) @(negedge clk);
      check($sformatf("vec%0d head held idx", v), idx, lo);
      check($sformatf("vec%0d head held rise", v), rise, vecs[v].lvl[lo]);
      drain(diff, vecs[v].lvl, $sformatf("vec%0d", v));
      prev = vecs[v].lvl;
    end

    // Overflow: FIFO full, line 5 rises then falls while still pending
    settle(8'h0F);
    settle(8'h2F);
    check("ovf not yet", ovf, 0);
    check("ovf pending level", level, 8'h2F);
    settle(8'h0F);
    check("ovf set", ovf, 1);
    check("ovf level", level, 8'h0F);
    drain(8'h2F, 8'h0F, "ovf");
    check("ovf sticky", ovf, 1);
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    check("ovf cleared", ovf, 0);

    // Async reset mid-cycle with events queued, inputs held high through it
    settle(8'hAA);
    check("pre-reset valid", valid, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async level", level, 8'h00);
    check("async valid", valid, 0);
    check("async idx", idx, 0);
    check("async rise", rise, 0);
    check("async ovf", ovf, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check("post-reset level", level, 8'hAA);
    drain(8'hAA, 8'hAA, "post-reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/switch_event_scanner.md
Name: switch_event_scanner

Overview:
- Input-side companion to the 8-bit `s_o` LED/segment driver in `fpga_top`.
- Samples 8 external switch/button lines and synchronizes them.
- Debounces each line against a shared sample tick.
- Reports each accepted level change as an event through a small FIFO with a valid/ready handshake, so control logic can react to user input.

Parameters:
- WIDTH, 8: number of input lines; event index width is clog2(WIDTH).
- TICK_DIV, 1200: clk_i cycles per sample tick (100 us at 12 MHz).
- STABLE_TICKS, 50: consecutive differing ticks needed to accept a change (5 ms).
- FIFO_DEPTH, 4: event FIFO entries; power of two, at least 2.

Ports:
- clk_i, input, 1: system clock (12 MHz).
- rst_i, input, 1: reset, asynchronous, active-high.
- s_i, input, WIDTH: raw asynchronous switch inputs.
- level_o, output, WIDTH: debounced levels.
- evt_valid_o, output, 1: FIFO head event available.
- evt_ready_i, input, 1: consumer accepts head event.
- evt_idx_o, output, clog2(WIDTH): line index of head event.
- evt_rise_o, output, 1: 1 = head event is a rising change, 0 = falling.
- overflow_o, output, 1: sticky; a change was merged or lost.
- clr_ovf_i, input, 1: single-cycle clear of overflow_o.

Behaviour:
- Reset (async assert, sync release):
  - level_o = 0; sync flops, prescaler, per-bit counters and pending bits = 0.
  - FIFO empty: evt_valid_o = 0, evt_idx_o = 0, evt_rise_o = 0.
  - overflow_o = 0.
  - Reset mid-operation discards queued events.
  - Inputs held high through reset generate rise events once stable.
- Synchronizer: 2 flops per bit. The synced value lags s_i by 2 clk_i cycles.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when count == TICK_DIV-1.
- Per-bit debounce, evaluated only on tick cycles:
  - If synced != level_o[i]: counter increments.
  - If synced == level_o[i]: counter clears to 0. A bounce therefore restarts qualification.
  - When the counter would reach STABLE_TICKS: level_o[i] toggles at that clock edge, the counter clears, and pending[i] is set.
  - Counter width is clog2(STABLE_TICKS+1). The counter never wraps.
- Change during pending: if pending[i] is already set when bit i toggles again, set overflow_o. pending[i] stays set, so only one event is queued, carrying the newest level.
- Arbiter:
  - Each cycle, if pending != 0 and the FIFO can accept, push the lowest set index.
  - The pushed entry is {idx, level_o[idx]} using the current level_o. That pending bit clears.
  - At most one push per cycle. Multiple simultaneous changes drain in ascending index order on consecutive cycles.
- FIFO:
  - evt_valid_o = (count != 0). Outputs show the head entry, registered, with no combinational path from evt_ready_i.
  - Pop occurs when evt_valid_o && evt_ready_i.
  - A push is allowed when count < FIFO_DEPTH, or when count == FIFO_DEPTH and a pop occurs the same cycle.
  - Push and pop in the same cycle leave count unchanged.
  - When full with no pop, events stay in pending. The FIFO never drops entries.
  - Head outputs are held stable while evt_valid_o && !evt_ready_i.
- Latency:
  - An isolated clean change on s_i updates level_o STABLE_TICKS ticks after the synced change is first sampled.
  - evt_valid_o rises 1 cycle after level_o changes, if the FIFO is empty.
- Overflow clear: clr_ovf_i clears overflow_o. If a set condition occurs in the same cycle, set wins.

Test Plan (TICK_DIV=4, STABLE_TICKS=3, FIFO_DEPTH=4 unless noted):
- Reset value: hold rst_i with s_i=8'h00 -> all outputs 0. Assert rst_i asynchronously mid-clock -> outputs clear before the next edge.
- Clean rise: s_i[2] 0->1 and held -> level_o=8'h04 after 3 ticks (about 12 cycles plus 2 sync cycles). One cycle later evt_valid_o=1, evt_idx_o=2, evt_rise_o=1. Pop with evt_ready_i=1 -> evt_valid_o=0.
- Bounce reject: toggle s_i[0] high for 2 ticks, low for 1, high for 2, then low -> level_o stays 0, no event, overflow_o=0.
- Simultaneous changes: s_i 8'h00->8'h81 -> level_o=8'h81 in one cycle. Events are (idx 0, rise) then (idx 7, rise) on consecutive cycles with evt_ready_i held 1.
- Backpressure: evt_ready_i=0, 6 separate lines change -> 4 entries are queued and head outputs stay stable. Release ready -> all 6 events arrive in order, none lost, overflow_o=0.
- Overflow: evt_ready_i=0, FIFO full, s_i[5] rises then falls (each stable) -> overflow_o=1. After drain, a single event (idx 5, rise=0) appears. clr_ovf_i pulse -> overflow_o=0.
